// File: rtl/multi_dataflow_stream_join_pkg.sv
// Shared definitions for the multi-stream join: FSM state type and default sizes.
package multi_dataflow_package;

  localparam int unsigned N_IN_DEF  = 3;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multi_dataflow_stream_join_fifo.sv
// Per-channel buffer: DEPTH-entry FIFO with head visible one cycle after a push.
module multi_dataflow_fifo
  import multi_dataflow_package::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/occupancy registers, flushed by reset or clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/multi_dataflow_stream_join.sv
// Joins N_IN buffered input streams into one output transaction per job step.
module multi_dataflow_stream_join
  import multi_dataflow_package::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   len_i,
  input  logic [N_IN-1:0]    mask_i,
  input  logic [N_IN*DW-1:0] in_data_i,
  input  logic [N_IN-1:0]    in_valid_i,
  output logic [N_IN-1:0]    in_ready_o,
  output logic [N_IN*DW-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   cnt_o
);

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [N_IN-1:0]  mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] push_cnt_q [N_IN];

  logic [N_IN-1:0]  fifo_empty, fifo_full, push, pop;
  logic [DW-1:0]    fifo_rdata [N_IN];
  logic             run, fire;

  assign run         = (state_q == ST_RUN);
  assign busy_o      = run;
  assign done_o      = (state_q == ST_DONE);
  assign cnt_o       = cnt_q;
  assign out_valid_o = run & (&(~fifo_empty | ~mask_q));
  assign fire        = out_valid_o & out_ready_i;

  // Per-channel handshakes and output packing; unmasked or empty lanes read as zero.
  always_comb begin
    in_ready_o = '0;
    push       = '0;
    pop        = '0;
    out_data_o = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      in_ready_o[k] = run & mask_q[k] & ~fifo_full[k] & (push_cnt_q[k] < len_q);
      push[k]       = in_valid_i[k] & in_ready_o[k];
      pop[k]        = fire & mask_q[k];
      if (mask_q[k] && !fifo_empty[k]) out_data_o[k*DW +: DW] = fifo_rdata[k];
    end
  end

  // Job FSM with its length, mask and transfer counters.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned k = 0; k < N_IN; k++) push_cnt_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q  <= len_i;
            mask_q <= mask_i;
            cnt_q  <= '0;
            for (int unsigned k = 0; k < N_IN; k++) push_cnt_q[k] <= '0;
            state_q <= ((len_i != '0) && (mask_i != '0)) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          for (int unsigned k = 0; k < N_IN; k++) begin
            if (push[k]) push_cnt_q[k] <= push_cnt_q[k] + CNT_W'(1);
          end
          if (fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == len_q) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // One buffer per input stream.
  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    multi_dataflow_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .push_i  (push[g]),
      .data_i  (in_data_i[g*DW +: DW]),
      .pop_i   (pop[g]),
      .data_o  (fifo_rdata[g]),
      .empty_o (fifo_empty[g]),
      .full_o  (fifo_full[g])
    );
  end

endmodule
